// File: rtl/rx_stream_arbiter.sv
// Packet-granular round-robin merge of two 64-bit AXI4-Stream rx sources.
// A grant is held from the first beat through the tlast handshake, so packets never interleave.
module rx_stream_arbiter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 user_clk,
  input  logic                 reset,
  input  logic                 arb_enable,
  input  logic [63:0]          s0_axis_tdata,
  input  logic [7:0]           s0_axis_tkeep,
  input  logic                 s0_axis_tvalid,
  input  logic                 s0_axis_tlast,
  output logic                 s0_axis_tready,
  input  logic [63:0]          s1_axis_tdata,
  input  logic [7:0]           s1_axis_tkeep,
  input  logic                 s1_axis_tvalid,
  input  logic                 s1_axis_tlast,
  output logic                 s1_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tid,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] pkt_count0,
  output logic [CNT_WIDTH-1:0] pkt_count1,
  output logic                 busy
);

  typedef enum logic {IDLE, STREAMING} state_t;

  state_t state, state_next;
  logic   grant_r, grant_next;
  logic   last_served_r, last_served_next;
  logic   streaming;
  logic   pkt_end;

  assign streaming = (state == STREAMING);
  assign pkt_end   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy      = streaming;

  // Datapath always follows grant_r; only valid/ready are gated by state.
  always_comb begin
    m_axis_tdata   = grant_r ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tkeep   = grant_r ? s1_axis_tkeep : s0_axis_tkeep;
    m_axis_tlast   = grant_r ? s1_axis_tlast : s0_axis_tlast;
    m_axis_tid     = grant_r;
    m_axis_tvalid  = streaming & (grant_r ? s1_axis_tvalid : s0_axis_tvalid);
    s0_axis_tready = streaming & ~grant_r & m_axis_tready;
    s1_axis_tready = streaming &  grant_r & m_axis_tready;
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant_r;
    last_served_next = last_served_r;
    case (state)
      IDLE: begin
        if (arb_enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
          state_next = STREAMING;
          if (s0_axis_tvalid && s1_axis_tvalid)
            grant_next = ~last_served_r;
          else
            grant_next = s1_axis_tvalid;
        end
      end
      STREAMING: begin
        if (pkt_end) begin
          state_next       = IDLE;
          last_served_next = grant_r;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // last_served_r resets to 1 so that port 0 wins the first contested arbitration.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant_r       <= 1'b0;
      last_served_r <= 1'b1;
      pkt_count0    <= '0;
      pkt_count1    <= '0;
    end else begin
      state         <= state_next;
      grant_r       <= grant_next;
      last_served_r <= last_served_next;
      if (pkt_end && !grant_r)
        pkt_count0 <= pkt_count0 + CNT_WIDTH'(1);
      if (pkt_end && grant_r)
        pkt_count1 <= pkt_count1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: packet-level round-robin model predicts the merged
// stream, a negedge monitor compares every output handshake against it.
module tb_rx_stream_arbiter;

  localparam int CW = 32;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  tid;
  } exp_t;

  logic          user_clk;
  logic          reset;
  logic          arb_enable;
  logic [63:0]   s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [7:0]    s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic          m_axis_tid;
  logic [CW-1:0] pkt_count0, pkt_count1;
  logic          busy;

  beat_t src0[$];
  beat_t src1[$];
  exp_t  sb[$];

  int            checks = 0;
  int            errors = 0;
  logic          model_last;
  logic [CW-1:0] exp_cnt0, exp_cnt1;
  logic          acc0, acc1;
  int            gap0, gap1;
  int            ready_mode;
  logic          gaps_on;
  int            out_beats;

  rx_stream_arbiter #(.CNT_WIDTH(CW)) dut (
    .user_clk(user_clk), .reset(reset), .arb_enable(arb_enable),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tready(m_axis_tready),
    .pkt_count0(pkt_count0), .pkt_count1(pkt_count1), .busy(busy)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: records source handshakes for the driver and scores every output beat.
  always @(negedge user_clk) begin
    exp_t e;
    acc0 = s0_axis_tvalid & s0_axis_tready;
    acc1 = s1_axis_tvalid & s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("tdata", m_axis_tdata, e.b.data);
        checkOutput("tkeep", 64'(m_axis_tkeep), 64'(e.b.keep));
        checkOutput("tlast", 64'(m_axis_tlast), 64'(e.b.last));
        checkOutput("tid", 64'(m_axis_tid), 64'(e.tid));
        checkOutput("other_tready", 64'(e.tid ? s0_axis_tready : s1_axis_tready), 64'd0);
        out_beats++;
      end
    end
  end

  task automatic add_packet(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (i == len - 1);
      if (port == 1) src1.push_back(b);
      else src0.push_back(b);
    end
  endtask

  // Packet-level reference: whole packets are taken alternately while both ports have
  // one pending, otherwise from whichever port still has traffic.
  task automatic predict();
    int    p0 = 0;
    int    p1 = 0;
    logic  pick;
    beat_t b;
    exp_t  e;
    while (p0 < src0.size() || p1 < src1.size()) begin
      if (p0 < src0.size() && p1 < src1.size()) pick = !model_last;
      else pick = (p1 < src1.size());
      do begin
        if (pick) begin b = src1[p1]; p1++; end
        else begin b = src0[p0]; p0++; end
        e.b = b;
        e.tid = pick;
        sb.push_back(e);
      end while (!b.last);
      model_last = pick;
      if (pick) exp_cnt1++;
      else exp_cnt0++;
    end
  endtask

  task automatic drive_sources();
    if (src0.size() > 0 && gap0 == 0) begin
      s0_axis_tvalid = 1'b1; s0_axis_tdata = src0[0].data;
      s0_axis_tkeep = src0[0].keep; s0_axis_tlast = src0[0].last;
    end else begin
      s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    end
    if (src1.size() > 0 && gap1 == 0) begin
      s1_axis_tvalid = 1'b1; s1_axis_tdata = src1[0].data;
      s1_axis_tkeep = src1[0].keep; s1_axis_tlast = src1[0].last;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    end
  endtask

  // One clock of source/sink behaviour; valid only drops between beats, never on a held beat.
  task automatic applyStimulus();
    beat_t b;
    @(posedge user_clk);
    #1;
    if (acc0 && src0.size() > 0) begin
      b = src0.pop_front();
      if (gaps_on && !b.last && $urandom_range(0, 2) == 0) gap0 = $urandom_range(1, 2);
    end else if (gap0 > 0) gap0--;
    if (acc1 && src1.size() > 0) begin
      b = src1.pop_front();
      if (gaps_on && !b.last && $urandom_range(0, 2) == 0) gap1 = $urandom_range(1, 2);
    end else if (gap1 > 0) gap1--;
    drive_sources();
    case (ready_mode)
      1:       m_axis_tready = !m_axis_tready;
      2:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic run_traffic(input int budget, output int steps);
    steps = 0;
    do begin
      applyStimulus();
      steps++;
    end while ((src0.size() > 0 || src1.size() > 0 || sb.size() > 0) && steps < budget);
    checkOutput("traffic_drained", 64'(src0.size() + src1.size() + sb.size()), 64'd0);
  endtask

  task automatic check_counts(input string tag);
    checkOutput({tag, "_pkt_count0"}, 64'(pkt_count0), 64'(exp_cnt0));
    checkOutput({tag, "_pkt_count1"}, 64'(pkt_count1), 64'(exp_cnt1));
  endtask

  task automatic flush_and_release();
    src0.delete(); src1.delete(); sb.delete();
    gap0 = 0; gap1 = 0;
    drive_sources();
    model_last = 1'b1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    repeat (2) @(negedge user_clk);
    reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_and_release();
  endtask

  initial begin
    int   steps;
    int   n;
    logic p;

    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   steps;
    int   n;
    logic p;

    reset = 1'b1; arb_enable = 1'b1; m_axis_tready = 1'b1;
    ready_mode = 0; gaps_on = 1'b0; out_beats = 0;
    gap0 = 0; gap1 = 0; acc0 = 1'b0; acc1 = 1'b0;
    drive_sources();
    do_reset();

    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
    checkOutput("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
    checkOutput("rst_m_tid", 64'(m_axis_tid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    check_counts("rst");

    // Single 4-beat packet on port 0: one bubble cycle, then pass-through.
    add_packet(0, 4);
    predict();
    applyStimulus();
    checkOutput("bubble_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("bubble_busy", 64'(busy), 64'd0);
    applyStimulus();
    checkOutput("first_beat_tvalid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("first_beat_busy", 64'(busy), 64'd1);
    run_traffic(200, steps);
    check_counts("single");

    // Both ports saturated with 3-beat packets: strict alternation, 4 cycles per packet.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_packet(0, 3);
      add_packet(1, 3);
    end
    predict();
    run_traffic(200, steps);
    checkOutput("b2b_cycles", 64'(steps), 64'd25);
    check_counts("b2b");

    // Toggling downstream ready plus mid-packet source gaps.
    ready_mode = 1;
    gaps_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add_packet(0, $urandom_range(1, 6));
      add_packet(1, $urandom_range(1, 6));
    end
    predict();
    run_traffic(2000, steps);
    check_counts("toggle");

    // Random ready, random gaps, uneven traffic per port.
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) add_packet(0, $urandom_range(1, 8));
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) add_packet(1, $urandom_range(1, 8));
      predict();
      run_traffic(3000, steps);
      check_counts("random");
    end

    // arb_enable dropped mid-packet: packet finishes, block parks in IDLE, then resumes fairly.
    ready_mode = 0;
    gaps_on = 1'b0;
    p = !model_last;
    add_packet(p, 5);
    add_packet(!p, 2);
    add_packet(p, 3);
    predict();
    out_beats = 0;
    n = 0;
    while (out_beats < 2 && n < 50) begin applyStimulus(); n++; end
    arb_enable = 1'b0;
    n = 0;
    while (sb.size() > 5 && n < 50) begin applyStimulus(); n++; end
    checkOutput("disable_pkt_done", 64'(sb.size()), 64'd5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("disabled_busy", 64'(busy), 64'd0);
      checkOutput("disabled_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      applyStimulus();
    end
    arb_enable = 1'b1;
    run_traffic(200, steps);
    check_counts("arb_enable");

    // Asynchronous reset on beat 3 of a packet.
    add_packet(0, 5);
    predict();
    out_beats = 0;
    n = 0;
    while (out_beats < 2 && n < 50) begin applyStimulus(); n++; end
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("async_rst_s0_tready", 64'(s0_axis_tready), 64'd0);
    checkOutput("async_rst_s1_tready", 64'(s1_axis_tready), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_count0", 64'(pkt_count0), 64'd0);
    checkOutput("async_rst_count1", 64'(pkt_count1), 64'd0);
    flush_and_release();
    add_packet(0, 2);
    add_packet(1, 2);
    predict();
    run_traffic(200, steps);
    check_counts("post_reset");

    // Counter wrap on port 0 from a preloaded all-ones value.
    @(posedge user_clk);
    #1;
    force dut.pkt_count0 = {CW{1'b1}};
    #1;
    release dut.pkt_count0;
    exp_cnt0 = {CW{1'b1}};
    checkOutput("preload_count0", 64'(pkt_count0), 64'(exp_cnt0));
    add_packet(0, 1);
    predict();
    run_traffic(200, steps);
    checkOutput("wrap_count0", 64'(pkt_count0), 64'd0);
    check_counts("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
